// File: rtl/lcd_responder.sv
// HD44780-style 8-bit write-only LCD target: 32-byte DDRAM, busy timing and protocol checking.
// State updates one clock after the E strobe; no backpressure, strobes while busy or too short are dropped and flag viol.
module lcd_responder #(
    parameter int CMD_CYCLES   = 2000,
    parameter int CLEAR_CYCLES = 82000,
    parameter int EMIN_CYCLES  = 12
) (
    input  logic        clock,
    input  logic        reset_n,
    input  logic        rs,
    input  logic        e,
    input  logic [7:0]  d,
    output logic        busy,
    output logic        init_done,
    output logic        display_on,
    output logic        cursor_on,
    output logic        blink_on,
    output logic [6:0]  cur_addr,
    input  logic [4:0]  rd_addr,
    output logic [7:0]  rd_data,
    output logic        viol,
    output logic [15:0] wr_count
);

    localparam int EW = $clog2(EMIN_CYCLES + 1);
    localparam logic [EW-1:0] EMIN_W = EW'(EMIN_CYCLES);

    typedef enum logic [1:0] {S_IDLE, S_CLEAR, S_BUSY} state_t;

    state_t        state_q, state_d;
    logic [31:0]   busy_cnt, cnt_d;
    logic [4:0]    fill_idx, fill_d;
    logic          e_q;
    logic [EW-1:0] e_cnt;
    logic          inc_mode, inc_d;
    logic          init_d, disp_d, curs_d, blink_d, viol_d;
    logic [6:0]    addr_d;
    logic [15:0]   wcnt_d;
    logic          strobe, wide, accept;
    logic          mem_we;
    logic [4:0]    mem_idx;
    logic [7:0]    mem_dat;
    logic [7:0]    mem [32];

    // Linear walk over the two 16-cell rows, wrapping row to row.
    function automatic logic [6:0] step_addr(input logic [6:0] a, input logic up);
        logic [6:0] r;
        if (up) begin
            if (a == 7'h0F)      r = 7'h40;
            else if (a == 7'h4F) r = 7'h00;
            else                 r = a + 7'd1;
        end else begin
            if (a == 7'h40)      r = 7'h0F;
            else if (a == 7'h00) r = 7'h4F;
            else                 r = a - 7'd1;
        end
        return r;
    endfunction

    assign strobe  = e_q & ~e;
    assign wide    = (e_cnt >= EMIN_W);
    assign accept  = strobe & wide & (state_q == S_IDLE);
    assign busy    = (state_q != S_IDLE);
    assign rd_data = mem[rd_addr];

    always_comb begin
        state_d = state_q;
        cnt_d   = busy_cnt;
        fill_d  = fill_idx;
        init_d  = init_done;
        disp_d  = display_on;
        curs_d  = cursor_on;
        blink_d = blink_on;
        addr_d  = cur_addr;
        inc_d   = inc_mode;
        viol_d  = viol;
        wcnt_d  = wr_count;
        mem_we  = 1'b0;
        mem_idx = {cur_addr[6], cur_addr[3:0]};
        mem_dat = d;

        if (strobe && (!wide || busy))
            viol_d = 1'b1;

        case (state_q)
            S_IDLE: begin
                if (accept) begin
                    if (wr_count != 16'hFFFF)
                        wcnt_d = wr_count + 16'd1;
                    state_d = S_BUSY;
                    cnt_d   = 32'(CMD_CYCLES - 1);
                    if (!init_done && !(!rs && d[7:5] == 3'b001))
                        viol_d = 1'b1;
                    if (rs) begin
                        mem_we = 1'b1;
                        addr_d = step_addr(cur_addr, inc_mode);
                    end else if (d[7]) begin
                        if (d[6:4] == 3'b000 || d[6:4] == 3'b100)
                            addr_d = d[6:0];
                        else
                            viol_d = 1'b1;
                    end else if (d[6]) begin
                        addr_d = cur_addr;
                    end else if (d[5]) begin
                        init_d = d[4] & d[3];
                        if (!(d[4] & d[3]))
                            viol_d = 1'b1;
                    end else if (d[4]) begin
                        if (!d[3])
                            addr_d = step_addr(cur_addr, d[2]);
                    end else if (d[3]) begin
                        disp_d  = d[2];
                        curs_d  = d[1];
                        blink_d = d[0];
                    end else if (d[2]) begin
                        // Shift-on-write (bit0) has no visible effect here, only direction is kept.
                        inc_d = d[1];
                    end else if (d[1]) begin
                        addr_d = 7'h00;
                    end else if (d[0]) begin
                        state_d = S_CLEAR;
                        cnt_d   = 32'(CLEAR_CYCLES - 1);
                        fill_d  = 5'd0;
                        addr_d  = 7'h00;
                        inc_d   = 1'b1;
                    end
                end
            end
            S_CLEAR: begin
                mem_we  = 1'b1;
                mem_idx = fill_idx;
                mem_dat = 8'h20;
                fill_d  = fill_idx + 5'd1;
                cnt_d   = busy_cnt - 32'd1;
                if (fill_idx == 5'd31)
                    state_d = S_BUSY;
            end
            S_BUSY: begin
                if (busy_cnt == 32'd0)
                    state_d = S_IDLE;
                else
                    cnt_d = busy_cnt - 32'd1;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= S_IDLE;
            busy_cnt   <= 32'd0;
            fill_idx   <= 5'd0;
            e_q        <= 1'b0;
            e_cnt      <= '0;
            init_done  <= 1'b0;
            display_on <= 1'b0;
            cursor_on  <= 1'b0;
            blink_on   <= 1'b0;
            cur_addr   <= 7'h00;
            inc_mode   <= 1'b1;
            viol       <= 1'b0;
            wr_count   <= 16'd0;
        end else begin
            state_q    <= state_d;
            busy_cnt   <= cnt_d;
            fill_idx   <= fill_d;
            e_q        <= e;
            if (!e)
                e_cnt <= '0;
            else if (e_cnt != '1)
                e_cnt <= e_cnt + EW'(1);
            init_done  <= init_d;
            display_on <= disp_d;
            cursor_on  <= curs_d;
            blink_on   <= blink_d;
            cur_addr   <= addr_d;
            inc_mode   <= inc_d;
            viol       <= viol_d;
            wr_count   <= wcnt_d;
        end
    end

    // DDRAM survives reset; a reset mid-clear simply stops the fill.
    always_ff @(posedge clock) begin
        if (mem_we)
            mem[mem_idx] <= mem_dat;
    end

endmodule

// File: tb/tb_lcd_responder.sv
// Bench for lcd_responder: directed LCD bus transfers against a position-based display model.
module tb_lcd_responder;

    localparam int CMD  = 40;
    localparam int CLR  = 100;
    localparam int EMIN = 12;

    logic        clock = 1'b0;
    logic        reset_n = 1'b1;
    logic        rs = 1'b0;
    logic        e = 1'b0;
    logic [7:0]  d = 8'h00;
    logic [4:0]  rd_addr = 5'd0;
    logic        busy, init_done, display_on, cursor_on, blink_on, viol;
    logic [6:0]  cur_addr;
    logic [7:0]  rd_data;
    logic [15:0] wr_count;

    int n_cmp = 0;
    int n_bad = 0;
    int cnt = 0;

    // Model: cursor as a position 0..31 in reading order, busy as a window of clock numbers.
    bit         m_init, m_disp, m_curs, m_blink, m_inc, m_viol;
    int         m_pos, m_count, m_bfrom, m_bto;
    int         m_clr = -1;
    logic [7:0] m_mem [32];
    bit         m_known [32];

    lcd_responder #(.CMD_CYCLES(CMD), .CLEAR_CYCLES(CLR), .EMIN_CYCLES(EMIN)) dut (
        .clock(clock), .reset_n(reset_n), .rs(rs), .e(e), .d(d),
        .busy(busy), .init_done(init_done), .display_on(display_on),
        .cursor_on(cursor_on), .blink_on(blink_on), .cur_addr(cur_addr),
        .rd_addr(rd_addr), .rd_data(rd_data), .viol(viol), .wr_count(wr_count)
    );

    initial forever #5 clock = ~clock;

    function automatic logic [6:0] pos2addr(int p);
        return 7'((p / 16) * 64 + (p % 16));
    endfunction

    function bit m_busy_at(int c);
        return (c >= m_bfrom) && (c <= m_bto);
    endfunction

    task automatic chk(string name, int act, int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, want 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task fold_clear(int c);
        if (m_clr >= 0) begin
            for (int i = 0; i < 32; i++)
                if (c >= m_clr + 1 + i) begin
                    m_mem[i] = 8'h20;
                    m_known[i] = 1'b1;
                end
            if (c >= m_clr + 32) m_clr = -1;
        end
    endtask

    task model_reset();
        fold_clear(cnt);
        m_clr = -1;
        m_init = 0; m_disp = 0; m_curs = 0; m_blink = 0;
        m_inc = 1; m_viol = 0; m_pos = 0; m_count = 0;
        m_bfrom = 1; m_bto = 0;
    endtask

    // n is the number of the clock edge that sees the strobe.
    task model_strobe(bit r, logic [7:0] v, int w, int n);
        int tgt;
        fold_clear(n - 1);
        if (w < EMIN || m_busy_at(n - 1)) begin
            m_viol = 1;
            return;
        end
        if (m_count < 65535) m_count++;
        if (!m_init && !(!r && v inside {[8'h20:8'h3F]})) m_viol = 1;
        m_bfrom = n;
        m_bto = n + CMD - 1;
        if (r) begin
            m_mem[m_pos] = v;
            m_known[m_pos] = 1'b1;
            m_pos = m_inc ? (m_pos + 1) % 32 : (m_pos + 31) % 32;
        end else if (v == 8'h01) begin
            m_clr = n; m_pos = 0; m_inc = 1;
            m_bto = n + CLR - 1;
        end else if (v inside {[8'h02:8'h03]}) m_pos = 0;
        else if (v inside {[8'h04:8'h07]}) m_inc = v[1];
        else if (v inside {[8'h08:8'h0F]}) {m_disp, m_curs, m_blink} = v[2:0];
        else if (v inside {[8'h10:8'h1F]}) begin
            if (!v[3]) m_pos = v[2] ? (m_pos + 1) % 32 : (m_pos + 31) % 32;
        end else if (v inside {[8'h20:8'h3F]}) begin
            m_init = v[4] && v[3];
            if (!m_init) m_viol = 1;
        end else if (v >= 8'h80) begin
            tgt = int'(v) - 128;
            if (tgt < 16) m_pos = tgt;
            else if (tgt >= 64 && tgt < 80) m_pos = tgt - 48;
            else m_viol = 1;
        end
    endtask

    // Every-cycle comparison against the model.
    initial begin
        forever begin
            @(negedge clock);
            cnt++;
            chk("busy", busy, m_busy_at(cnt));
            chk("init_done", init_done, m_init);
            chk("display_on", display_on, m_disp);
            chk("cursor_on", cursor_on, m_curs);
            chk("blink_on", blink_on, m_blink);
            chk("cur_addr", cur_addr, pos2addr(m_pos));
            chk("viol", viol, m_viol);
            chk("wr_count", wr_count, m_count);
            if (m_clr >= 0 && cnt >= m_clr + 1 + int'(rd_addr))
                chk("rd_data", rd_data, 8'h20);
            else if (m_known[rd_addr])
                chk("rd_data", rd_data, m_mem[rd_addr]);
        end
    end

    task automatic xfer(bit r, logic [7:0] v, int w);
        @(posedge clock);
        #1;
        rs = r; d = v; e = 1'b1;
        repeat (w) @(posedge clock);
        #1;
        e = 1'b0;
        @(posedge clock);
        model_strobe(r, v, w, cnt + 1);
        #1;
        rs = 1'b0; d = 8'h00;
    endtask

    task automatic wait_idle(output int len);
        len = 0;
        for (int k = 0; k < 1000; k++) begin
            @(negedge clock);
            #1;
            if (!busy) return;
            len++;
            rd_addr = rd_addr + 5'd1;
        end
        chk("idle_timeout", busy, 0);
    endtask

    task automatic cmd(bit r, logic [7:0] v);
        int len;
        xfer(r, v, 20);
        wait_idle(len);
    endtask

    task automatic peek(int idx, logic [7:0] exp, string name);
        @(negedge clock);
        #1;
        rd_addr = 5'(idx);
        #1;
        chk(name, rd_data, exp);
    endtask

    task automatic do_reset();
        @(negedge clock);
        #1;
        reset_n = 1'b0; e = 1'b0; rs = 1'b0; d = 8'h00;
        model_reset();
        #1;
        chk("busy_at_reset", busy, 0);
        repeat (3) @(negedge clock);
        #1;
        reset_n = 1'b1;
    endtask

    initial begin
        int len;
        model_reset();
        #2;
        reset_n = 1'b0;
        repeat (3) @(negedge clock);
        #1;
        reset_n = 1'b1;
        chk("rst_busy", busy, 0);
        chk("rst_init", init_done, 0);
        chk("rst_addr", cur_addr, 0);
        chk("rst_viol", viol, 0);
        chk("rst_count", wr_count, 0);

        // Function set 0x38 with a 20-clock E.
        xfer(0, 8'h38, 20);
        wait_idle(len);
        chk("init_busy_len", len, CMD);
        chk("init_done_set", init_done, 1);
        chk("init_count", wr_count, 1);
        chk("init_viol", viol, 0);

        // Clear display.
        xfer(0, 8'h01, 20);
        wait_idle(len);
        chk("clear_busy_len", len, CLR);
        for (int i = 0; i < 32; i++) peek(i, 8'h20, "clear_entry");
        chk("clear_addr", cur_addr, 0);

        // Row wrap on increment.
        cmd(0, 8'h8F); cmd(1, 8'h41); cmd(1, 8'h42);
        peek(15, 8'h41, "idx15_A");
        peek(16, 8'h42, "idx16_B");
        chk("ab_addr", cur_addr, 7'h41);

        // Wrap on decrement.
        cmd(0, 8'h04); cmd(0, 8'h80); cmd(1, 8'h5A);
        peek(0, 8'h5A, "idx0_Z");
        chk("z_addr", cur_addr, 7'h4F);

        cmd(0, 8'h0F);
        chk("flags_all", {display_on, cursor_on, blink_on}, 3'b111);
        cmd(0, 8'h0C);
        chk("flags_disp", {display_on, cursor_on, blink_on}, 3'b100);
        cmd(0, 8'h06); cmd(0, 8'h14);
        chk("shift_right_wrap", cur_addr, 7'h00);
        cmd(0, 8'h10);
        chk("shift_left_wrap", cur_addr, 7'h4F);
        cmd(0, 8'h18);
        chk("display_shift", cur_addr, 7'h4F);
        cmd(0, 8'h02);
        chk("home", cur_addr, 7'h00);
        cmd(0, 8'h40);
        chk("cgram_count", wr_count, 16);
        xfer(1, 8'h4D, EMIN);
        wait_idle(len);
        chk("emin_accepted", wr_count, 17);
        chk("clean_viol", viol, 0);

        // Strobe on the final busy clock is dropped; one clock later it is taken.
        xfer(0, 8'h06, 20);
        xfer(1, 8'h51, CMD - 2);
        chk("busy_drop_viol", viol, 1);
        chk("busy_drop_count", wr_count, 18);
        chk("busy_drop_addr", cur_addr, 7'h01);
        wait_idle(len);
        xfer(0, 8'h06, 20);
        xfer(1, 8'h52, CMD - 1);
        chk("after_busy_count", wr_count, 20);
        wait_idle(len);

        // Short E pulses.
        do_reset();
        cmd(0, 8'h38);
        xfer(1, 8'h51, 5);
        chk("short_viol", viol, 1);
        chk("short_count", wr_count, 1);
        chk("short_addr", cur_addr, 0);
        xfer(1, 8'h51, EMIN - 1);
        wait_idle(len);

        // Illegal DDRAM address.
        do_reset();
        cmd(0, 8'h38);
        cmd(0, 8'hA0);
        chk("a0_viol", viol, 1);
        chk("a0_addr", cur_addr, 0);
        chk("a0_count", wr_count, 2);

        // Writes before init are flagged but still executed.
        do_reset();
        cmd(1, 8'h3F);
        chk("preinit_viol", viol, 1);
        chk("preinit_count", wr_count, 1);
        peek(0, 8'h3F, "preinit_data");
        cmd(0, 8'h30);
        chk("bad_fset_init", init_done, 0);

        // Reset during the clear fill.
        do_reset();
        cmd(0, 8'h38); cmd(0, 8'h80);
        for (int i = 0; i < 32; i++) cmd(1, 8'(8'h30 + i));
        chk("fill_wrap_addr", cur_addr, 0);
        xfer(0, 8'h01, 20);
        repeat (9) @(negedge clock);
        do_reset();
        peek(8, 8'h20, "midclr_idx8");
        peek(9, 8'h39, "midclr_idx9");
        peek(31, 8'h4F, "midclr_idx31");
        chk("midclr_addr", cur_addr, 0);

        repeat (3) @(negedge clock);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
